pipelined_adder: RTL

//   Parametrised, pipelined successor to the 4-bit combinational ripple adder.

---
 rtl/pipelined_adder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit unsigned add of A + B + cin split into STAGES ripple chunks (skewed pipeline).
// Latency: result STAGES cycles after accept, plus one cycle per stall; sustains one result per cycle.
// Backpressure: global stall, in_ready = !out_valid | out_ready; every stage holds while stalled.
// Build option: define PIPE_ADDER_SUB_EN to add port in_sub (computes A + ~B + 1, in_cin ignored).
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
);

    // WIDTH must be a multiple of STAGES; each stage resolves one CW-bit chunk.
    localparam int CW = WIDTH / STAGES;

    // Half adder: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full adder from two half adders and an OR: returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        logic [1:0] h1;
        logic [1:0] h2;
        h1 = half_add(x, y);
        h2 = half_add(h1[0], ci);
        return {h1[1] | h2[1], h2[0]};
    endfunction

    // The whole pipe moves or the whole pipe holds; there is no per-stage skid.
    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still waiting to be added once this stage's chunk is done.
        localparam int RW = WIDTH - (k + 1) * CW;

        // Operand bits arriving at this stage: this chunk in the low CW bits, the rest above it.
        logic [RW+CW-1:0]    a_src;
        logic [RW+CW-1:0]    b_src;
        logic                c_in;
        logic                sub_in;
        logic                vld_in;

        logic [CW-1:0]       b_eff;
        logic [CW-1:0]       chunk_sum;
        logic                chunk_cout;
        logic                carry;
        logic [1:0]          fa;
        logic [(k+1)*CW-1:0] sum_nxt;

        // Stage registers: low sum bits resolved so far, carry into the next chunk, valid.
        logic [(k+1)*CW-1:0] sum_q;
        logic                c_q;
        logic                vld_q;

        if (k == 0) begin : g_first
            assign a_src  = in_a;
            assign b_src  = in_b;
`ifdef PIPE_ADDER_SUB_EN
            assign sub_in = in_sub;
`else
            assign sub_in = 1'b0;
`endif
            // Subtract forces the +1 of the two's complement and overrides in_cin.
            assign c_in   = sub_in | in_cin;
            assign vld_in = in_valid;
        end else begin : g_next
            assign a_src  = g_stage[k-1].g_fwd.a_q;
            assign b_src  = g_stage[k-1].g_fwd.b_q;
            assign sub_in = g_stage[k-1].g_fwd.sub_q;
            assign c_in   = g_stage[k-1].c_q;
            assign vld_in = g_stage[k-1].vld_q;
        end

        // B is stored raw and inverted chunk by chunk using the op's own sub flag.
        assign b_eff = b_src[CW-1:0] ^ {CW{sub_in}};

        // Ripple this chunk bit by bit through the full-adder chain.
        always_comb begin
            carry     = c_in;
            fa        = 2'b00;
            chunk_sum = '0;
            for (int i = 0; i < CW; i++) begin
                fa           = full_add(a_src[i], b_eff[i], carry);
                chunk_sum[i] = fa[0];
                carry        = fa[1];
            end
            chunk_cout = carry;
        end

        if (k == 0) begin : g_sum_first
            assign sum_nxt = chunk_sum;
        end else begin : g_sum_next
            assign sum_nxt = {chunk_sum, g_stage[k-1].sum_q};
        end

        // Capture resolved sum bits, chunk carry and valid; hold all of it while stalled.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sum_q <= '0;
                c_q   <= 1'b0;
                vld_q <= 1'b0;
            end else if (advance) begin
                sum_q <= sum_nxt;
                c_q   <= chunk_cout;
                vld_q <= vld_in;
            end
        end

        // Every stage but the last carries the untouched upper operand chunks and the op type.
        if (k < STAGES - 1) begin : g_fwd
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;
            logic          sub_q;

            // Forward the not-yet-added operand bits alongside the partial sum.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sub_q <= 1'b0;
                end else if (advance) begin
                    a_q   <= a_src[RW+CW-1:CW];
                    b_q   <= b_src[RW+CW-1:CW];
                    sub_q <= sub_in;
                end
            end
        end
    end

    // Last stage holds the complete result; its carry is the untruncated top bit.
    assign out_valid = g_stage[STAGES-1].vld_q;
    assign out_sum   = {g_stage[STAGES-1].c_q, g_stage[STAGES-1].sum_q};

endmodule
